// File: rtl/smps_pwm_pkg.sv
// Shared constants and helpers for the SMPS multi-channel PWM generator.
package smps_pwm_pkg;

  localparam int          DEF_PERIOD = 200;
  localparam int          DEF_TON    = 100;
  localparam int unsigned MIN_PERIOD = 2;

  // A period below two cycles cannot produce both a high and a low phase.
  function automatic int unsigned clamp_period(input int unsigned p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

endpackage

// File: rtl/pwm_chan_cmp.sv
// One PWM channel: phase-shifted position within the period and registered compare.
module pwm_chan_cmp #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_ton,
  input  logic [CNT_W-1:0] i_phase,
  output logic             o_pwm
);
  import smps_pwm_pkg::*;

  logic [CNT_W:0] ph_eff;
  logic [CNT_W:0] pos;
  logic           pwm_d, pwm_q;

  // One extra bit keeps cnt + Pa - ph from wrapping.
  always_comb begin
    ph_eff = (i_phase >= i_period) ? '0 : {1'b0, i_phase};
    if ({1'b0, i_cnt} >= ph_eff) pos = {1'b0, i_cnt} - ph_eff;
    else                         pos = {1'b0, i_cnt} + {1'b0, i_period} - ph_eff;
    pwm_d = i_en && (pos < {1'b0, i_ton});
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) pwm_q <= 1'b0;
    else       pwm_q <= pwm_d;
  end

  assign o_pwm = pwm_q;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared period counter, double-buffered period/on-time/phase
// that swap in only at a period boundary (or immediately while disabled).
module pwm_multi_gen #(
  parameter int CNT_W      = 8,
  parameter int N_CH       = 2,
  parameter int DEF_PERIOD = smps_pwm_pkg::DEF_PERIOD,
  parameter int DEF_TON    = smps_pwm_pkg::DEF_TON
) (
  input  logic                  i_clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic [CNT_W-1:0]      i_period,
  input  logic [N_CH*CNT_W-1:0] i_ton,
  input  logic [N_CH*CNT_W-1:0] i_phase,
  input  logic                  i_load,
  output logic [N_CH-1:0]       o_pwm,
  output logic                  o_sync,
  output logic                  o_pend
);
  import smps_pwm_pkg::*;

  localparam logic [CNT_W-1:0]      RST_PERIOD = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0]      RST_TON1   = CNT_W'(DEF_TON);
  localparam logic [N_CH*CNT_W-1:0] RST_TON    = {N_CH{RST_TON1}};

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      act_period_q, act_period_d;
  logic [N_CH*CNT_W-1:0] act_ton_q, act_ton_d;
  logic [N_CH*CNT_W-1:0] act_phase_q, act_phase_d;
  logic [CNT_W-1:0]      pend_period_q, pend_period_d;
  logic [N_CH*CNT_W-1:0] pend_ton_q, pend_ton_d;
  logic [N_CH*CNT_W-1:0] pend_phase_q, pend_phase_d;
  logic                  pend_q, pend_d;
  logic                  sync_q, sync_d;
  logic                  tc, xfer;

  always_comb begin
    tc   = (cnt_q == act_period_q - CNT_W'(1));
    // The transfer reads the pending set as it stood before this edge, so a load
    // landing on the transfer edge is kept pending for the following boundary.
    xfer = pend_q && (tc || !i_en);

    pend_period_d = pend_period_q;
    pend_ton_d    = pend_ton_q;
    pend_phase_d  = pend_phase_q;
    if (i_load) begin
      pend_period_d = CNT_W'(clamp_period(32'(i_period)));
      pend_ton_d    = i_ton;
      pend_phase_d  = i_phase;
    end

    act_period_d = xfer ? pend_period_q : act_period_q;
    act_ton_d    = xfer ? pend_ton_q    : act_ton_q;
    act_phase_d  = xfer ? pend_phase_q  : act_phase_q;

    pend_d = i_load || (pend_q && !xfer);
    cnt_d  = (!i_en || tc) ? '0 : cnt_q + CNT_W'(1);
    sync_d = i_en && (cnt_q == '0);
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      act_period_q  <= RST_PERIOD;
      act_ton_q     <= RST_TON;
      act_phase_q   <= '0;
      pend_period_q <= RST_PERIOD;
      pend_ton_q    <= RST_TON;
      pend_phase_q  <= '0;
      pend_q        <= 1'b0;
      sync_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      act_period_q  <= act_period_d;
      act_ton_q     <= act_ton_d;
      act_phase_q   <= act_phase_d;
      pend_period_q <= pend_period_d;
      pend_ton_q    <= pend_ton_d;
      pend_phase_q  <= pend_phase_d;
      pend_q        <= pend_d;
      sync_q        <= sync_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pwm_chan_cmp #(.CNT_W(CNT_W)) u_cmp (
      .i_clk    (i_clk),
      .reset    (reset),
      .i_en     (i_en),
      .i_cnt    (cnt_q),
      .i_period (act_period_q),
      .i_ton    (act_ton_q[k*CNT_W +: CNT_W]),
      .i_phase  (act_phase_q[k*CNT_W +: CNT_W]),
      .o_pwm    (o_pwm[k])
    );
  end

  assign o_sync = sync_q;
  assign o_pend = pend_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen: defaults, interleaving, edge duties, deferred loads, enable/reset.
module tb_pwm_multi_gen;

  logic        i_clk = 1'b0;
  logic        reset;
  logic        i_en;
  logic [7:0]  i_period;
  logic [15:0] i_ton;
  logic [15:0] i_phase;
  logic        i_load;
  logic [1:0]  o_pwm;
  logic        o_sync;
  logic        o_pend;

  int total = 0;
  int bad   = 0;

  pwm_multi_gen #(.CNT_W(8), .N_CH(2), .DEF_PERIOD(200), .DEF_TON(100)) dut (
    .i_clk    (i_clk),
    .reset    (reset),
    .i_en     (i_en),
    .i_period (i_period),
    .i_ton    (i_ton),
    .i_phase  (i_phase),
    .i_load   (i_load),
    .o_pwm    (o_pwm),
    .o_sync   (o_sync),
    .o_pend   (o_pend)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Samples are taken 1 time unit after each rising edge; inputs change there too.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int p, input int t0, input int t1, input int ph0, input int ph1);
    i_period = 8'(p);
    i_ton    = {8'(t1), 8'(t0)};
    i_phase  = {8'(ph1), 8'(ph0)};
  endtask

  task automatic do_load(input int p, input int t0, input int t1, input int ph0, input int ph1);
    set_req(p, t0, t1, ph0, ph1);
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    chk("pend_set", 32'(o_pend), 32'd1);
  endtask

  // Waits for the transfer, then steps onto the first sample of the new set (o_sync high).
  task automatic apply();
    int n = 0;
    while (o_pend && n < 500) begin
      step();
      n++;
    end
    chk("pend_clear", 32'(o_pend), 32'd0);
    step();
    chk("sync_first", 32'(o_sync), 32'd1);
  endtask

  initial begin
    int c;
    logic p0;
    reset  = 1'b0;
    i_en   = 1'b1;
    i_load = 1'b0;
    set_req(200, 100, 100, 0, 0);
    #1 reset = 1'b1;

    // reset state
    step();
    step();
    chk("rst_pwm",  32'(o_pwm),  32'd0);
    chk("rst_sync", 32'(o_sync), 32'd0);
    chk("rst_pend", 32'(o_pend), 32'd0);
    reset = 1'b0;

    // defaults: 100 high / 100 low, sync every 200 aligned with pwm rise
    for (int j = 0; j < 600; j++) begin
      step();
      c = j % 200;
      chk("dflt", 32'({o_sync, o_pwm}), 32'({c == 0, c < 100, c < 100}));
    end
    chk("dflt_pend", 32'(o_pend), 32'd0);

    // interleaved channels, P=10, ph={0,5}
    do_load(10, 5, 5, 0, 5);
    apply();
    for (int j = 0; j < 30; j++) begin
      if (j > 0) step();
      c  = j % 10;
      p0 = (c < 5);
      chk("ilv", 32'({o_sync, o_pwm}), 32'({c == 0, ~p0, p0}));
    end

    // ton=0 stays low, ton>=P stays high
    do_load(10, 0, 12, 0, 0);
    apply();
    for (int j = 0; j < 20; j++) begin
      if (j > 0) step();
      c = j % 10;
      chk("edge_duty", 32'({o_sync, o_pwm}), 32'({c == 0, 1'b1, 1'b0}));
    end

    // period 1 clamps to 2
    do_load(1, 1, 1, 0, 0);
    apply();
    for (int j = 0; j < 10; j++) begin
      if (j > 0) step();
      c = j % 2;
      chk("clamp", 32'({o_sync, o_pwm}), 32'({c == 0, c == 0, c == 0}));
    end

    // deferred loads: at cnt=7 of P=20, then at terminal count of P=8, then overwrite
    do_load(20, 10, 10, 0, 0);
    apply();
    for (int j = 1; j <= 60; j++) begin
      if (j == 7)  begin set_req(8, 4, 4, 0, 0);   i_load = 1'b1; end
      if (j == 43) begin set_req(12, 6, 6, 0, 0);  i_load = 1'b1; end
      if (j == 46) begin set_req(6, 3, 3, 0, 0);   i_load = 1'b1; end
      step();
      i_load = 1'b0;
      case (j)
        7:  chk("dfr_pend7",   32'(o_pend), 32'd1);
        18: chk("dfr_pend18",  32'(o_pend), 32'd1);
        19: begin
              chk("dfr_pend19", 32'(o_pend), 32'd0);
              chk("dfr_sync19", 32'(o_sync), 32'd0);
            end
        20: chk("dfr_sync20",  32'(o_sync), 32'd1);
        27: chk("dfr_sync27",  32'(o_sync), 32'd0);
        28: chk("dfr_sync28",  32'(o_sync), 32'd1);
        36: chk("dfr_sync36",  32'(o_sync), 32'd1);
        43: chk("tc_pend43",   32'(o_pend), 32'd1);
        44: chk("tc_sync44",   32'(o_sync), 32'd1);
        50: chk("tc_pend50",   32'(o_pend), 32'd1);
        51: chk("tc_pend51",   32'(o_pend), 32'd0);
        52: chk("ovw_sync52",  32'({o_sync, o_pwm}), 32'(3'b111));
        55: chk("ovw_pwm55",   32'(o_pwm),  32'd0);
        57: chk("ovw_sync57",  32'(o_sync), 32'd0);
        58: chk("ovw_sync58",  32'(o_sync), 32'd1);
        default: ;
      endcase
    end

    // enable drop, load while disabled, restart at pos 0
    do_load(20, 10, 10, 0, 0);
    apply();
    for (int j = 1; j <= 5; j++) step();
    chk("en_pre", 32'(o_pwm), 32'(2'b11));
    i_en = 1'b0;
    step();
    chk("en_off1", 32'({o_sync, o_pwm}), 32'd0);
    step();
    chk("en_off2", 32'({o_sync, o_pwm}), 32'd0);
    set_req(10, 3, 8, 0, 0);
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    chk("dis_pend", 32'(o_pend), 32'd1);
    step();
    chk("dis_xfer", 32'(o_pend), 32'd0);
    i_en = 1'b1;
    step();
    chk("restart0", 32'({o_sync, o_pwm}), 32'(3'b111));
    step();
    chk("restart1", 32'({o_sync, o_pwm}), 32'(3'b011));
    step();
    chk("restart2", 32'({o_sync, o_pwm}), 32'(3'b011));
    step();
    chk("restart3", 32'({o_sync, o_pwm}), 32'(3'b010));

    // asynchronous reset between edges
    set_req(30, 5, 5, 0, 0);
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    chk("pre_rst_pwm",  32'(o_pwm),  32'(2'b10));
    chk("pre_rst_pend", 32'(o_pend), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_pwm",  32'(o_pwm),  32'd0);
    chk("async_pend", 32'(o_pend), 32'd0);
    chk("async_sync", 32'(o_sync), 32'd0);
    step();
    chk("rst_hold", 32'({o_pend, o_sync, o_pwm}), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst", 32'({o_pend, o_sync, o_pwm}), 32'(4'b0111));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi_gen.md
# pwm_multi_gen

Parametrised multi-channel PWM / clock generator for the SMPS control path, the successor to the fixed divide-by-200 50 % clock. One shared period counter drives N_CH channels, each with its own runtime on-time and phase offset. Period, on-times and phases are double-buffered and take effect only at a period boundary, so switching waveforms are never glitched. It sits between the control-law logic, which supplies duty and phase words, and the gate-drive outputs.

## Interface
- CNT_W, 8: width of the counter, period, on-time and phase words.
- N_CH, 2: number of PWM channels.
- DEF_PERIOD, 200: period loaded by reset, in i_clk cycles.
- DEF_TON, 100: on-time loaded by reset, all channels.

Ports:
- i_clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- i_en  in  1  run enable.
- i_period  in  CNT_W  requested period P, in cycles.
- i_ton  in  N_CH*CNT_W  per-channel on-time; channel k is at bits [k*CNT_W +: CNT_W].
- i_phase  in  N_CH*CNT_W  per-channel phase offset, packed the same way as i_ton.
- i_load  in  1  single-cycle strobe that captures i_period, i_ton and i_phase into the pending set.
- o_pwm  out  N_CH  registered PWM outputs.
- o_sync  out  1  registered one-cycle pulse marking the start of each period.
- o_pend  out  1  high while a captured set has not yet been applied.

## Operation
- Register sets:
  - pending set: written on any edge where i_load=1.
  - active set: drives counting and comparison.
  - Reset values: active period=DEF_PERIOD, active ton=DEF_TON, active phase=0. The pending set resets to the same values.
- Period clamp: a period below 2 is stored as 2 on capture.
- Counter cnt runs 0..Pa-1, where Pa is the active period.
  - Terminal count: cnt==Pa-1.
  - At terminal count, cnt wraps to 0.
- Transfer from pending to active:
  - Occurs on the terminal-count edge when o_pend=1. The new Pa governs the wrap from that edge on.
  - If i_en=0, the transfer occurs on the first edge with o_pend=1.
- o_pend:
  - Set on the edge where i_load=1.
  - Cleared on the transfer edge.
  - i_load on the terminal-count edge with o_pend=0: data is captured and applied at the next terminal count.
  - i_load with o_pend=1: overwrites the pending set; only the last write is applied.
- Per-channel position: pos_k = cnt - ph_k if cnt ≥ ph_k, else cnt + Pa - ph_k.
  - Computed at CNT_W+1 bits, so there is no overflow.
  - ph_k ≥ Pa is treated as 0.
- Channel output: o_pwm[k] is registered from (pos_k < ton_k).
  - ton_k=0 gives a constant low output.
  - ton_k ≥ Pa gives a constant high output.
- o_sync is registered from (cnt==0).
- i_en=0:
  - cnt is held at 0 synchronously.
  - o_pwm and o_sync are driven to 0 on the next edge.
  - The pending→active transfer still operates as described above.

## Timing
- Reset: cnt=0, o_pwm=0, o_sync=0, o_pend=0. Values hold for as long as reset is asserted.
- Output latency: outputs lag cnt by one cycle. The outputs in cycle n+1 reflect cnt in cycle n.
- Start-up with i_en=1 at reset release:
  - The first edge registers pos(0): o_sync=1 and every channel with ph=0 and ton>0 goes high. The same edge advances cnt to 1.
  - With default settings, o_pwm[k] is high for 100 cycles and low for 100 cycles. The pattern repeats every 200 cycles, and o_sync pulses every 200 cycles.
- Enable rise: the first edge with i_en=1 behaves identically to start-up from reset.
- Parameter change: new values are visible on the outputs in the cycle after cnt first equals 0 under the new active set.
- Mid-period reset: takes effect asynchronously. All outputs go to 0 immediately, without waiting for a clock edge.

## Structure
- Package smps_pwm_pkg holds:
  - default constants DEF_PERIOD and DEF_TON;
  - MIN_PERIOD=2;
  - a function that clamps the period.
- Sub-module pwm_chan_cmp, instantiated once per channel via generate:
  - inputs: cnt, Pa, ton_k, ph_k;
  - contains the modular position calculation and the registered output bit.
- The top level holds the counter, both register sets, and the o_pend and o_sync logic.

## Test plan
- Defaults: reset, then i_en=1 for 600 cycles.
  - Each o_pwm must be high 100 cycles and low 100 cycles.
  - o_sync must pulse every 200 cycles, coincident with each rising edge of o_pwm.
- Interleaved channels: load P=10, ton={5,5}, ph={0,5}.
  - After the boundary, o_pwm[1] must equal ~o_pwm[0].
  - Each channel must show a period of 10.
- Edge duties: load ton={0,12} with P=10.
  - o_pwm[0] must stay low.
  - o_pwm[1] must stay high.
  - A period of 1 must be loaded as 2, giving an o_sync pulse every 2 cycles.
- Deferred load: with P=20, pulse i_load at cnt=7 requesting P=8.
  - o_pend must be high until the terminal count at cnt=19.
  - The next o_sync must follow 20 cycles after the previous one; subsequent o_sync pulses must come every 8 cycles.
  - A second case pulses i_load exactly at terminal count; the load must apply one period later.
- Enable and reset: deassert i_en mid-period.
  - The outputs must go to 0 on the next edge.
  - After re-enabling, output must restart at pos 0.
  - Asserting reset between edges must force o_pwm=0 and o_pend=0 immediately.
